// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command decoder: command codes, direction
// arguments, the default sync byte and the frame-parser state encoding.
package uart_cmd_pkg;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  localparam logic [7:0] CMD_DIR   = 8'h01;
  localparam logic [7:0] CMD_START = 8'h02;
  localparam logic [7:0] CMD_PAUSE = 8'h03;
  localparam logic [7:0] CMD_RESET = 8'h04;

  localparam logic [7:0] DIR_UP      = 8'h00;
  localparam logic [7:0] DIR_DOWN    = 8'h01;
  localparam logic [7:0] DIR_LEFT    = 8'h02;
  localparam logic [7:0] DIR_RIGHT   = 8'h03;
  localparam logic [7:0] DIR_RELEASE = 8'hFF;

  localparam logic [1:0] ST_WAIT_SYNC = 2'd0;
  localparam logic [1:0] ST_GET_CMD   = 2'd1;
  localparam logic [1:0] ST_GET_ARG   = 2'd2;
  localparam logic [1:0] ST_GET_CHK   = 2'd3;

  // A frame is executable when its command is known and, for DIR, its argument is legal.
  function automatic logic cmd_is_legal(input logic [7:0] cmd, input logic [7:0] arg);
    logic legal;
    legal = 1'b0;
    case (cmd)
      CMD_DIR:                        legal = (arg <= DIR_RIGHT) || (arg == DIR_RELEASE);
      CMD_START, CMD_PAUSE, CMD_RESET: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_cmd_timer.sv
// Reloadable down-counter: load starts it at CYCLES, stop idles it, and
// expired is high for the single cycle in which a running count sits at 0.
module cmd_timer #(
  parameter int unsigned CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic stop,
  output logic expired
);

  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] count;
  logic         running;

  // load has priority over stop; an expired timer idles itself unless reloaded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      running <= 1'b0;
    end else if (load) begin
      count   <= W'(CYCLES);
      running <= 1'b1;
    end else if (stop) begin
      count   <= '0;
      running <= 1'b0;
    end else if (running) begin
      if (count == '0) running <= 1'b0;
      else             count   <= count - W'(1);
    end
  end

  assign expired = running && (count == '0);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses SYNC/CMD/ARG/CHK frames from the UART byte stream into Pac-Man
// control signals, with inter-byte timeout and direction auto-release.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES    = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [1:0] dir,
  output logic       dir_active,
  output logic       start_pulse,
  output logic       pause,
  output logic       game_reset_pulse,
  output logic       frame_ok,
  output logic       err_pulse,
  output logic [7:0] err_count
);

  logic [1:0] state, next_state;
  logic [7:0] cmd_reg, arg_reg;
  logic       tmo_load, tmo_stop, tmo_expired;
  logic       hold_load, hold_stop, hold_expired;
  logic       frame_good, frame_bad, timeout_err;

  cmd_timer #(.CYCLES(TIMEOUT_CYCLES)) u_byte_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmo_load),
    .stop    (tmo_stop),
    .expired (tmo_expired)
  );

  cmd_timer #(.CYCLES(HOLD_CYCLES)) u_hold_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (hold_load),
    .stop    (hold_stop),
    .expired (hold_expired)
  );

  // A received byte always takes precedence over a timeout in the same cycle.
  always_comb begin
    next_state  = state;
    tmo_load    = 1'b0;
    tmo_stop    = 1'b0;
    frame_good  = 1'b0;
    frame_bad   = 1'b0;
    timeout_err = 1'b0;
    case (state)
      ST_WAIT_SYNC: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          next_state = ST_GET_CMD;
          tmo_load   = 1'b1;
        end
      end
      ST_GET_CMD, ST_GET_ARG: begin
        if (rx_valid) begin
          next_state = (state == ST_GET_CMD) ? ST_GET_ARG : ST_GET_CHK;
          tmo_load   = 1'b1;
        end else if (tmo_expired) begin
          next_state  = ST_WAIT_SYNC;
          timeout_err = 1'b1;
        end
      end
      default: begin
        if (rx_valid) begin
          next_state = ST_WAIT_SYNC;
          tmo_stop   = 1'b1;
          if ((rx_data == (cmd_reg ^ arg_reg)) && cmd_is_legal(cmd_reg, arg_reg))
            frame_good = 1'b1;
          else
            frame_bad = 1'b1;
        end else if (tmo_expired) begin
          next_state  = ST_WAIT_SYNC;
          timeout_err = 1'b1;
        end
      end
    endcase
  end

  assign hold_load = frame_good && (cmd_reg == CMD_DIR) && (arg_reg <= DIR_RIGHT);
  assign hold_stop = frame_good && (((cmd_reg == CMD_DIR) && (arg_reg == DIR_RELEASE)) ||
                                    (cmd_reg == CMD_RESET));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_WAIT_SYNC;
      cmd_reg <= '0;
      arg_reg <= '0;
    end else begin
      state <= next_state;
      if (rx_valid && (state == ST_GET_CMD)) cmd_reg <= rx_data;
      if (rx_valid && (state == ST_GET_ARG)) arg_reg <= rx_data;
    end
  end

  // Game-control outputs; a fresh DIR frame beats a simultaneous hold expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir              <= '0;
      dir_active       <= 1'b0;
      start_pulse      <= 1'b0;
      pause            <= 1'b0;
      game_reset_pulse <= 1'b0;
      frame_ok         <= 1'b0;
      err_pulse        <= 1'b0;
      err_count        <= '0;
    end else begin
      start_pulse      <= frame_good && (cmd_reg == CMD_START);
      game_reset_pulse <= frame_good && (cmd_reg == CMD_RESET);
      frame_ok         <= frame_good;
      err_pulse        <= frame_bad || timeout_err;
      if ((frame_bad || timeout_err) && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
      if (frame_good && (cmd_reg == CMD_PAUSE))
        pause <= ~pause;
      else if (frame_good && (cmd_reg == CMD_RESET))
        pause <= 1'b0;
      if (hold_load) begin
        dir        <= arg_reg[1:0];
        dir_active <= 1'b1;
      end else if (hold_stop || hold_expired) begin
        dir_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed scenarios plus random
// frames compared against a frame-level behavioural model.
module tb_uart_cmd_decoder;

  localparam int unsigned TMO  = 200;
  localparam int unsigned HOLD = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [1:0] dir;
  logic       dir_active, start_pulse, pause, game_reset_pulse, frame_ok, err_pulse;
  logic [7:0] err_count;

  int checks = 0;
  int failures = 0;

  // model state
  logic [1:0] exp_dir = 2'd0;
  logic       exp_active = 1'b0;
  logic       exp_pause = 1'b0;
  logic [7:0] exp_err = 8'd0;
  int exp_ok = 0, exp_errp = 0, exp_start = 0, exp_gr = 0;

  // observed pulse counts
  int n_ok = 0, n_errp = 0, n_start = 0, n_gr = 0, n_overlap = 0;

  uart_cmd_decoder #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO), .HOLD_CYCLES(HOLD)) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .dir              (dir),
    .dir_active       (dir_active),
    .start_pulse      (start_pulse),
    .pause            (pause),
    .game_reset_pulse (game_reset_pulse),
    .frame_ok         (frame_ok),
    .err_pulse        (err_pulse),
    .err_count        (err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_ok)               n_ok++;
      if (err_pulse)              n_errp++;
      if (start_pulse)            n_start++;
      if (game_reset_pulse)       n_gr++;
      if (frame_ok && err_pulse)  n_overlap++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap = 1'b1);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic model_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
    bit ok;
    ok = (k == (c ^ a));
    if (ok) begin
      if (c == 8'h01)                        ok = (a <= 8'd3) || (a == 8'hFF);
      else if (c >= 8'h02 && c <= 8'h04)     ok = 1'b1;
      else                                   ok = 1'b0;
    end
    if (!ok) begin
      exp_errp++;
      if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    end else begin
      exp_ok++;
      if (c == 8'h01) begin
        if (a == 8'hFF) exp_active = 1'b0;
        else begin exp_dir = a[1:0]; exp_active = 1'b1; end
      end else if (c == 8'h02) exp_start++;
      else if (c == 8'h03) exp_pause = ~exp_pause;
      else begin exp_gr++; exp_pause = 1'b0; exp_active = 1'b0; end
    end
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k,
                            input bit gap = 1'b1);
    send_byte(8'hA5, gap);
    send_byte(c, gap);
    send_byte(a, gap);
    send_byte(k, gap);
    model_frame(c, a, k);
  endtask

  task automatic model_reset();
    exp_dir = 2'd0; exp_active = 1'b0; exp_pause = 1'b0; exp_err = 8'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dir, dir_active, pause, err_count, start_pulse, game_reset_pulse, frame_ok, err_pulse} !== 16'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got dir=%0d act=%0b pause=%0b err=%0d pulses=%b%b%b%b, want all 0",
               dir, dir_active, pause, err_count, start_pulse, game_reset_pulse, frame_ok, err_pulse);
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_dir_hold();
    send_frame(8'h01, 8'h02, 8'h03);
    checks++;
    if ({dir, dir_active, pause, err_count} !== {exp_dir, exp_active, exp_pause, exp_err} || exp_dir !== 2'd2) begin
      failures++;
      $display("[TB] FAIL dir_left: got dir=%0d act=%0b, want dir=2 act=1", dir, dir_active);
    end
    checks++;
    if (n_ok !== exp_ok) begin
      failures++;
      $display("[TB] FAIL dir_frame_ok: got %0d frame_ok pulses, want %0d", n_ok, exp_ok);
    end
    repeat (HOLD - 50) @(negedge clk);
    checks++;
    if (dir_active !== 1'b1) begin
      failures++;
      $display("[TB] FAIL dir_still_held: got act=%0b, want 1", dir_active);
    end
    repeat (100) @(negedge clk);
    exp_active = 1'b0;
    checks++;
    if ({dir, dir_active} !== {2'd2, 1'b0}) begin
      failures++;
      $display("[TB] FAIL dir_release: got dir=%0d act=%0b, want dir=2 act=0", dir, dir_active);
    end
  endtask

  task automatic test_pause_start();
    send_frame(8'h03, 8'h00, 8'h03);
    checks++;
    if (pause !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pause_on: got %0b, want 1", pause);
    end
    send_frame(8'h03, 8'h00, 8'h03);
    checks++;
    if (pause !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pause_off: got %0b, want 0", pause);
    end
    send_frame(8'h02, 8'h00, 8'h02);
    repeat (4) @(negedge clk);
    checks++;
    if (n_start !== exp_start || exp_start != 1) begin
      failures++;
      $display("[TB] FAIL start_pulse_count: got %0d, want %0d", n_start, exp_start);
    end
  endtask

  task automatic test_errors();
    send_frame(8'h01, 8'h02, 8'h07);
    checks++;
    if ({dir, dir_active, pause, err_count} !== {exp_dir, exp_active, exp_pause, exp_err} || err_count !== 8'd1) begin
      failures++;
      $display("[TB] FAIL bad_checksum: got dir=%0d act=%0b err=%0d, want dir=%0d act=%0b err=1",
               dir, dir_active, err_count, exp_dir, exp_active);
    end
    send_frame(8'h09, 8'h00, 8'h09);
    checks++;
    if (err_count !== 8'd2) begin
      failures++;
      $display("[TB] FAIL unknown_cmd: got err=%0d, want 2", err_count);
    end
    send_frame(8'h01, 8'h05, 8'h04);
    checks++;
    if ({err_count, n_errp} !== {exp_err, exp_errp} || err_count !== 8'd3) begin
      failures++;
      $display("[TB] FAIL bad_dir_arg: got err=%0d pulses=%0d, want err=3 pulses=%0d", err_count, n_errp, exp_errp);
    end
  endtask

  task automatic test_timeout();
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TMO + 5) @(negedge clk);
    exp_errp++;
    exp_err = exp_err + 8'd1;
    checks++;
    if ({err_count, n_errp} !== {exp_err, exp_errp}) begin
      failures++;
      $display("[TB] FAIL timeout_err: got err=%0d pulses=%0d, want err=%0d pulses=%0d",
               err_count, n_errp, exp_err, exp_errp);
    end
    send_frame(8'h01, 8'h00, 8'h01);
    checks++;
    if ({dir, dir_active} !== {2'd0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL after_timeout_dir: got dir=%0d act=%0b, want dir=0 act=1", dir, dir_active);
    end
  endtask

  task automatic test_game_reset();
    send_frame(8'h03, 8'h00, 8'h03);
    send_frame(8'h04, 8'h00, 8'h04);
    checks++;
    if ({dir_active, pause, n_gr} !== {1'b0, 1'b0, exp_gr} || exp_gr != 1) begin
      failures++;
      $display("[TB] FAIL game_reset: got act=%0b pause=%0b gr_pulses=%0d, want 0 0 %0d",
               dir_active, pause, n_gr, exp_gr);
    end
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    repeat (4) @(negedge clk);
    checks++;
    if ({err_count, n_errp} !== {exp_err, exp_errp}) begin
      failures++;
      $display("[TB] FAIL garbage_bytes: got err=%0d pulses=%0d, want err=%0d pulses=%0d",
               err_count, n_errp, exp_err, exp_errp);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h01, 8'h03, 8'h02, 1'b0);
    send_frame(8'h03, 8'h00, 8'h03, 1'b0);
    @(negedge clk);
    checks++;
    if ({dir, dir_active, pause, err_count} !== {exp_dir, exp_active, exp_pause, exp_err}) begin
      failures++;
      $display("[TB] FAIL back_to_back: got dir=%0d act=%0b pause=%0b err=%0d, want %0d %0b %0b %0d",
               dir, dir_active, pause, err_count, exp_dir, exp_active, exp_pause, exp_err);
    end
  endtask

  task automatic test_random();
    logic [7:0] c, a, k;
    int sel;
    send_frame(8'h04, 8'h00, 8'h04);
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0, 1, 2, 3: c = 8'(sel + 1);
        4:          c = 8'($urandom_range(5, 255));
        default:    c = 8'h01;
      endcase
      if (sel == 5)                          a = 8'hFF;
      else if ($urandom_range(0, 3) == 0)    a = 8'($urandom_range(0, 255));
      else                                   a = 8'($urandom_range(0, 3));
      k = c ^ a;
      if ($urandom_range(0, 4) == 0) k = k ^ 8'($urandom_range(1, 255));
      send_frame(c, a, k);
      checks++;
      if ({dir, dir_active, pause, err_count} !== {exp_dir, exp_active, exp_pause, exp_err}) begin
        failures++;
        $display("[TB] FAIL random_frame_%0d (%h %h %h): got dir=%0d act=%0b pause=%0b err=%0d, want %0d %0b %0b %0d",
                 i, c, a, k, dir, dir_active, pause, err_count, exp_dir, exp_active, exp_pause, exp_err);
      end
    end
    checks++;
    if ({n_ok, n_errp, n_start, n_gr, n_overlap} !== {exp_ok, exp_errp, exp_start, exp_gr, 32'd0}) begin
      failures++;
      $display("[TB] FAIL pulse_totals: got ok=%0d err=%0d start=%0d gr=%0d overlap=%0d, want %0d %0d %0d %0d 0",
               n_ok, n_errp, n_start, n_gr, n_overlap, exp_ok, exp_errp, exp_start, exp_gr);
    end
  endtask

  task automatic test_midframe_reset();
    send_byte(8'hA5);
    send_byte(8'h01);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({dir, dir_active, pause, err_count, start_pulse, game_reset_pulse, frame_ok, err_pulse} !== 16'h0) begin
      failures++;
      $display("[TB] FAIL midframe_reset: got dir=%0d act=%0b pause=%0b err=%0d, want all 0",
               dir, dir_active, pause, err_count);
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    send_frame(8'h01, 8'h01, 8'h00);
    checks++;
    if ({dir, dir_active, err_count} !== {2'd1, 1'b1, 8'd0}) begin
      failures++;
      $display("[TB] FAIL post_reset_dir: got dir=%0d act=%0b err=%0d, want 1 1 0", dir, dir_active, err_count);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) send_frame(8'h01, 8'h02, 8'h00, 1'b0);
    @(negedge clk);
    checks++;
    if (err_count !== 8'hFF || exp_err !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL err_saturate: got %0d, want 255", err_count);
    end
  endtask

  initial begin
    test_reset();
    test_dir_hold();
    test_pause_start();
    test_errors();
    test_timeout();
    test_game_reset();
    test_back_to_back();
    test_random();
    test_midframe_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
